d_reg_pipe: RTL



---
 rtl/d_reg_pipe.sv | 91 +++++++++
 1 files changed

// File: rtl/d_reg_pipe.sv
// d_reg_pipe: WIDTH-bit, DEPTH-stage enabled delay line with complementary outputs,
// a selectable tap and saturating fill tracking.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (all stages <= RESET_VAL, fill <= 0)
//   d       data into stage 0
//   enable  advance the pipeline on this edge
//   clear   synchronous flush of stages and fill; wins over enable
//   sel     tap select, stage index 0..DEPTH-1 (out-of-range selects the last stage)
//   q       last stage
//   qbar    bitwise complement of q, taken from the same register
//   q_tap   stage[sel], combinational mux
//   fill    enabled shifts since reset/clear, saturating at DEPTH
//   full    fill == DEPTH
module d_reg_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned SelW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned FillW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             enable,
  input  logic             clear,
  input  logic [SelW-1:0]  sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] q_tap,
  output logic [FillW-1:0] fill,
  output logic             full
);

  localparam logic [FillW-1:0] FillMax = FillW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [FillW-1:0] fill_q, fill_d;

  // Next state: clear > enable > hold.
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_d[i] = RESET_VAL;
      end
      fill_d = '0;
    end else if (enable) begin
      stage_d[0] = d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_d[i] = stage_q[i-1];
      end
      if (fill_q != FillMax) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= RESET_VAL;
      end
      fill_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_d[i];
      end
      fill_q <= fill_d;
    end
  end

  // Tap mux defaults to the last stage so sel values >= DEPTH read q.
  always_comb begin
    q_tap = stage_q[DEPTH-1];
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sel == SelW'(i)) begin
        q_tap = stage_q[i];
      end
    end
  end

  assign q    = stage_q[DEPTH-1];
  assign qbar = ~stage_q[DEPTH-1];
  assign fill = fill_q;
  assign full = (fill_q == FillMax);

endmodule
